// File: rtl/data_64_to_8_tx.sv
// 64-bit to byte serializer for the UART transmit path, least-significant byte first.
// Each byte is handed off with a one-cycle tx_start and confirmed by a tx_done rising edge.
module data_64_to_8_tx #(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_64,
  input  logic        load,
  input  logic        tx_done,
  output logic [7:0]  data_8,
  output logic        tx_start,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [63:0]   sreg, sreg_n;
  logic [2:0]    idx, idx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [7:0]    data_8_n;
  logic          tx_start_n, busy_n, done_n, error_n;
  logic          load_d, tx_done_d;
  logic          load_rise, tx_done_rise;

  assign load_rise    = load & ~load_d;
  assign tx_done_rise = tx_done & ~tx_done_d;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sreg      <= 64'd0;
      idx       <= 3'd0;
      tcnt      <= '0;
      data_8    <= 8'd0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      load_d    <= 1'b0;
      tx_done_d <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      idx       <= idx_n;
      tcnt      <= tcnt_n;
      data_8    <= data_8_n;
      tx_start  <= tx_start_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      load_d    <= load;
      tx_done_d <= tx_done;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_n    = state;
    sreg_n     = sreg;
    idx_n      = idx;
    tcnt_n     = tcnt;
    data_8_n   = data_8;
    tx_start_n = 1'b0;
    busy_n     = busy;
    done_n     = 1'b0;
    error_n    = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_rise) begin
          sreg_n  = data_64;
          idx_n   = 3'd0;
          busy_n  = 1'b1;
          state_n = S_SEND;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SEND: begin
        data_8_n   = sreg[7:0];
        tx_start_n = 1'b1;
        tcnt_n     = '0;
        state_n    = S_WAIT;
      end
      S_WAIT: begin
        // A confirming edge takes priority over a coincident timeout expiry.
        if (tx_done_rise) begin
          if (idx == 3'd7) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            sreg_n  = sreg >> 8;
            idx_n   = idx + 3'd1;
            state_n = S_SEND;
          end
        end else if (TO_EN && (tcnt == T_LAST)) begin
          error_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
